pc_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the CUPS core.
- Fetches 16-bit instructions over a request/acknowledge memory port and slices the immediate fields onto the immediate extender's inputs (aoi 4b, branch 8b, jump 12b).
- Drives the extender's select and sign-extend controls, consumes its 16-bit result and updates the program counter.
- Pulses the ALU enable for register operations.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> memory/extender/ALU bundle. The master modport is the
// sequencer; the slave side is the memory port, extender and ALU flag.
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        cond_z;
  logic [3:0]  ext_tb;
  logic [7:0]  ext_tc;
  logic [11:0] ext_td;
  logic [1:0]  ext_sel;
  logic        ext_sz;
  logic [15:0] imm;
  logic [15:0] ir;
  logic        alu_en;
  logic        halted;

  modport master (
    output imem_req, imem_addr, ext_tb, ext_tc, ext_td, ext_sel, ext_sz,
           ir, alu_en, halted,
    input  imem_ack, imem_rdata, cond_z, imm
  );

  modport slave (
    input  imem_req, imem_addr, ext_tb, ext_tc, ext_td, ext_sel, ext_sz,
           ir, alu_en, halted,
    output imem_ack, imem_rdata, cond_z, imm
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller: 3 cycles per instruction plus ack wait cycles;
// fetch request is held until imem_ack, HALT is absorbing until reset.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input logic            i_clk,
  input logic            i_rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_imem_req;
  logic        r_alu_en;
  logic        r_halted;

  logic [3:0]  w_op;
  logic        w_is_halt;
  logic        w_is_alu;
  logic        w_is_beq;
  logic        w_is_bne;
  logic        w_is_jmp;
  logic        w_taken;
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_next;
  logic [1:0]  w_ext_sel;
  logic        w_ext_sz;

  // HALT_OP is checked first so a parameter override may alias any opcode.
  assign w_op      = r_ir[15:12];
  assign w_is_halt = (w_op == HALT_OP);
  assign w_is_alu  = !w_is_halt && !w_op[3];
  assign w_is_beq  = !w_is_halt && (w_op == 4'h8);
  assign w_is_bne  = !w_is_halt && (w_op == 4'h9);
  assign w_is_jmp  = !w_is_halt && (w_op == 4'hA);

  always_comb begin
    w_ext_sel = 2'b00;
    w_ext_sz  = 1'b0;
    if (w_is_beq || w_is_bne) begin
      w_ext_sel = 2'b01;
      w_ext_sz  = 1'b1;
    end else if (w_is_jmp) begin
      w_ext_sel = 2'b10;
    end
  end

  assign w_taken   = (w_is_beq && bus.cond_z) || (w_is_bne && !bus.cond_z);
  assign w_pc_inc  = r_pc + 16'd1;
  assign w_pc_next = w_is_jmp  ? bus.imm :
                     w_taken   ? w_pc_inc + bus.imm :
                     w_is_halt ? r_pc : w_pc_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 16'h0000;
      r_imem_req <= 1'b0;
      r_alu_en   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Ack only counts once the request is visible on the port.
          if (r_imem_req && bus.imem_ack) begin
            r_ir       <= bus.imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          r_alu_en <= w_is_alu;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_alu_en <= 1'b0;
          r_pc     <= w_pc_next;
          if (w_is_halt) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_imem_req <= 1'b0;
          end else begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_HALT: begin
          r_imem_req <= 1'b0;
          r_alu_en   <= 1'b0;
          r_halted   <= 1'b1;
        end
        default: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b0;
          r_alu_en   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.ir        = r_ir;
  assign bus.ext_tb    = r_ir[3:0];
  assign bus.ext_tc    = r_ir[7:0];
  assign bus.ext_td    = r_ir[11:0];
  assign bus.ext_sel   = w_ext_sel;
  assign bus.ext_sz    = w_ext_sz;
  assign bus.alu_en    = r_alu_en;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: instruction table driven through a memory/extender
// model, next-pc expectations queued at fetch and checked after EXEC.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate extender model
  always_comb begin
    bus.imm = 16'h0000;
    case (bus.ext_sel)
      2'b00:   bus.imm = bus.ext_sz ? {{12{bus.ext_tb[3]}}, bus.ext_tb} : {12'h000, bus.ext_tb};
      2'b01:   bus.imm = bus.ext_sz ? {{8{bus.ext_tc[7]}}, bus.ext_tc} : {8'h00, bus.ext_tc};
      2'b10:   bus.imm = {4'h0, bus.ext_td};
      default: bus.imm = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        cz;
    int          waits;
    logic        spur;
    logic [1:0]  sel;
    logic        sz;
    logic [15:0] imm;
    logic        alu;
    logic [15:0] next_pc;
    logic        halt;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_pc_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_instr(input vec_t v);
    int t;
    logic [15:0] exp_pc;
    t = 0;
    while (bus.imem_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("req_rise", {15'd0, bus.imem_req}, 16'd1);
    if (bus.imem_req !== 1'b1) return;
    chk("fetch_addr", bus.imem_addr, v.addr);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk("wait_req", {15'd0, bus.imem_req}, 16'd1);
      chk("wait_addr", bus.imem_addr, v.addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.instr;
    exp_pc_q.push_back(v.next_pc);
    tick();
    // DECODE
    bus.imem_ack   = v.spur;
    bus.imem_rdata = 16'hDEAD;
    bus.cond_z     = v.cz;
    chk("dec_ir", bus.ir, v.instr);
    chk("dec_req", {15'd0, bus.imem_req}, 16'd0);
    chk("dec_sel", {14'd0, bus.ext_sel}, {14'd0, v.sel});
    chk("dec_sz", {15'd0, bus.ext_sz}, {15'd0, v.sz});
    chk("dec_td", {4'd0, bus.ext_td}, {4'd0, v.instr[11:0]});
    chk("dec_alu", {15'd0, bus.alu_en}, 16'd0);
    tick();
    // EXEC
    bus.imem_ack = 1'b0;
    chk("exec_ir", bus.ir, v.instr);
    chk("exec_alu", {15'd0, bus.alu_en}, {15'd0, v.alu});
    chk("exec_imm", bus.imm, v.imm);
    tick();
    bus.cond_z = ~v.cz;
    exp_pc = (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : 16'hXXXX;
    chk("next_pc", bus.imem_addr, exp_pc);
    chk("post_alu", {15'd0, bus.alu_en}, 16'd0);
    chk("post_req", {15'd0, bus.imem_req}, {15'd0, !v.halt});
    chk("post_halted", {15'd0, bus.halted}, {15'd0, v.halt});
  endtask

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    //          addr      instr     cz  w  sp sel    sz  imm       alu next     halt
    tbl[0]  = '{16'h0000, 16'h0003, 0, 0, 0, 2'b00, 0, 16'h0003, 1, 16'h0001, 0};
    tbl[1]  = '{16'h0001, 16'hA010, 0, 0, 0, 2'b10, 0, 16'h0010, 0, 16'h0010, 0};
    tbl[2]  = '{16'h0010, 16'h80FE, 1, 0, 0, 2'b01, 1, 16'hFFFE, 0, 16'h000F, 0};
    tbl[3]  = '{16'h000F, 16'hA010, 0, 1, 0, 2'b10, 0, 16'h0010, 0, 16'h0010, 0};
    tbl[4]  = '{16'h0010, 16'h80FE, 0, 0, 0, 2'b01, 1, 16'hFFFE, 0, 16'h0011, 0};
    tbl[5]  = '{16'h0011, 16'hA020, 0, 0, 0, 2'b10, 0, 16'h0020, 0, 16'h0020, 0};
    tbl[6]  = '{16'h0020, 16'h9005, 0, 0, 0, 2'b01, 1, 16'h0005, 0, 16'h0026, 0};
    tbl[7]  = '{16'h0026, 16'h9005, 1, 0, 0, 2'b01, 1, 16'h0005, 0, 16'h0027, 0};
    tbl[8]  = '{16'h0027, 16'hA123, 0, 0, 0, 2'b10, 0, 16'h0123, 0, 16'h0123, 0};
    tbl[9]  = '{16'h0123, 16'h7ABC, 1, 0, 0, 2'b00, 0, 16'h000C, 1, 16'h0124, 0};
    tbl[10] = '{16'h0124, 16'hB000, 0, 0, 1, 2'b00, 0, 16'h0000, 0, 16'h0125, 0};
    tbl[11] = '{16'h0125, 16'h8005, 1, 0, 0, 2'b01, 1, 16'h0005, 0, 16'h012B, 0};
    tbl[12] = '{16'h012B, 16'hA000, 0, 0, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 0};
    tbl[13] = '{16'h0000, 16'h80FE, 1, 0, 0, 2'b01, 1, 16'hFFFE, 0, 16'hFFFF, 0};
    tbl[14] = '{16'hFFFF, 16'hC000, 0, 3, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0};
    tbl[15] = '{16'h0000, 16'h8F80, 1, 0, 0, 2'b01, 1, 16'hFF80, 0, 16'hFF81, 0};
    tbl[16] = '{16'hFF81, 16'hF000, 0, 0, 0, 2'b00, 0, 16'h0000, 0, 16'hFF81, 1};

    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.cond_z     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_alu", {15'd0, bus.alu_en}, 16'd0);
    chk("rst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rst_sel", {14'd0, bus.ext_sel}, 16'd0);
    chk("rst_sz", {15'd0, bus.ext_sz}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("req_after_rst", {15'd0, bus.imem_req}, 16'd1);

    for (int i = 0; i < 17; i++) do_instr(tbl[i]);

    // Halt: absorbing, stray acks ignored
    for (int c = 0; c < 10; c++) begin
      bus.imem_ack   = c[0];
      bus.imem_rdata = 16'h1234;
      tick();
      chk("halt_req", {15'd0, bus.imem_req}, 16'd0);
      chk("halt_flag", {15'd0, bus.halted}, 16'd1);
      chk("halt_pc", bus.imem_addr, 16'hFF81);
      chk("halt_ir", bus.ir, 16'hF000);
    end
    bus.imem_ack = 1'b0;

    // Reset out of HALT
    #2 rst_n = 1'b0;
    #1;
    chk("rst_halt_flag", {15'd0, bus.halted}, 16'd0);
    chk("rst_halt_pc", bus.imem_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("refetch_req", {15'd0, bus.imem_req}, 16'd1);

    // Async reset mid-FETCH with a pending ack
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hA555;
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", {15'd0, bus.imem_req}, 16'd0);
    chk("async_pc", bus.imem_addr, 16'h0000);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst_n        = 1'b1;
    chk("ack_discarded", bus.ir, 16'h0000);

    rv = '{16'h0000, 16'h0003, 0, 0, 0, 2'b00, 0, 16'h0003, 1, 16'h0001, 0};
    do_instr(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
